// File: rtl/issue_arbiter_pkg.sv
// Shared constants, index types and the ROB age helper for the oldest-first issue arbiter.
package issue_arbiter_pkg;

  localparam int NUM_ENTRIES  = 16;
  localparam int NUM_FU       = 3;
  localparam int ROB_IDX_W    = 6;
  localparam int ENTRY_W      = 4;
  localparam int LS_PER_CYCLE = 1;
  localparam int CNT_W        = 2;
  localparam int LS_W         = $clog2(NUM_FU + 1);

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [ENTRY_W-1:0]   entry_idx_t;

  // Distance from the ROB head with natural wrap; 0 means the oldest in-flight op.
  function automatic rob_idx_t rob_age(input rob_idx_t idx, input rob_idx_t head);
    return idx - head;
  endfunction

endpackage

// File: rtl/issue_arbiter_oldest_select.sv
// Combinational oldest-candidate finder: smallest age wins, lower entry index breaks ties.
module issue_arbiter_oldest_select
  import issue_arbiter_pkg::*;
(
  input  logic [NUM_ENTRIES-1:0] cand,
  input  rob_idx_t               age [NUM_ENTRIES],
  output logic                   found,
  output entry_idx_t             index
);

  rob_idx_t best_age;

  // Strict less-than keeps the first (lowest-index) entry among equal ages.
  always_comb begin
    found    = 1'b0;
    index    = '0;
    best_age = '1;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cand[i] && (!found || (age[i] < best_age))) begin
        found    = 1'b1;
        index    = ENTRY_W'(i);
        best_age = age[i];
      end
    end
  end

endmodule

// File: rtl/issue_arbiter.sv
// Oldest-first issue arbiter: picks up to NUM_FU ready RS entries per cycle and binds them to free FUs.
module issue_arbiter
  import issue_arbiter_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_ENTRIES-1:0]           entry_valid,
  input  logic [NUM_ENTRIES-1:0]           entry_ready,
  input  logic [NUM_ENTRIES-1:0]           entry_is_ls,
  input  logic [NUM_ENTRIES*ROB_IDX_W-1:0] entry_rob_idx,
  input  logic [ROB_IDX_W-1:0]             rob_head,
  input  logic [NUM_FU-1:0]                fu_available,
  output logic [NUM_FU-1:0]                grant_valid,
  output logic [NUM_FU*ENTRY_W-1:0]        grant_entry,
  output logic [NUM_ENTRIES-1:0]           grant_vector,
  output logic [CNT_W-1:0]                 grant_count
);

  logic [NUM_FU-1:0]         grant_valid_q,  grant_valid_d;
  logic [NUM_FU*ENTRY_W-1:0] grant_entry_q,  grant_entry_d;
  logic [NUM_ENTRIES-1:0]    grant_vector_q, grant_vector_d;
  logic [CNT_W-1:0]          grant_count_q,  grant_count_d;

  // Last cycle's grants block re-issue of the same entry and re-use of the same FU for one cycle.
  logic [NUM_ENTRIES-1:0] entry_mask;
  logic [NUM_FU-1:0]      fu_mask;
  assign entry_mask = grant_vector_q;
  assign fu_mask    = grant_valid_q;

  logic [NUM_ENTRIES-1:0] eligible;
  logic [NUM_FU-1:0]      fu_free;
  logic [CNT_W-1:0]       free_cnt;
  rob_idx_t               age [NUM_ENTRIES];

  assign eligible = entry_valid & entry_ready & ~entry_mask;
  assign fu_free  = fu_available & ~fu_mask;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      age[i] = rob_age(entry_rob_idx[i*ROB_IDX_W +: ROB_IDX_W], rob_head);
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      free_cnt = free_cnt + CNT_W'(fu_free[k]);
    end
  end

  logic [NUM_FU-1:0] pass_ok;
  entry_idx_t        pass_idx [NUM_FU];

  // Pass p only binds if at least p+1 FUs are free; the LS budget carries down the chain.
  for (genvar p = 0; p < NUM_FU; p++) begin : g_pass
    logic [NUM_ENTRIES-1:0] taken_in;
    logic [NUM_ENTRIES-1:0] taken_out;
    logic [NUM_ENTRIES-1:0] cand;
    logic [LS_W-1:0]        ls_in;
    logic [LS_W-1:0]        ls_out;
    logic                   found;
    logic                   bind_ok;
    entry_idx_t             idx;

    if (p == 0) begin : g_first
      assign taken_in = '0;
      assign ls_in    = '0;
    end else begin : g_next
      assign taken_in = g_pass[p-1].taken_out;
      assign ls_in    = g_pass[p-1].ls_out;
    end

    assign cand = eligible & ~taken_in &
                  ((ls_in >= LS_W'(LS_PER_CYCLE)) ? ~entry_is_ls : '1);

    issue_arbiter_oldest_select u_sel (
      .cand  (cand),
      .age   (age),
      .found (found),
      .index (idx)
    );

    assign bind_ok   = found & (free_cnt > CNT_W'(p));
    assign taken_out = taken_in | (bind_ok ? (NUM_ENTRIES'(1) << idx) : '0);
    assign ls_out    = ls_in + LS_W'(bind_ok & entry_is_ls[idx]);

    assign pass_ok[p]  = bind_ok;
    assign pass_idx[p] = idx;
  end

  // Passes are handed to free FUs in ascending FU order, so pass p lands on the p-th free FU.
  logic [1:0] pass_sel;

  always_comb begin
    grant_valid_d  = '0;
    grant_entry_d  = '0;
    grant_vector_d = '0;
    grant_count_d  = '0;
    pass_sel       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (fu_free[k] && (pass_sel < 2'(NUM_FU))) begin
        if (pass_ok[pass_sel]) begin
          grant_valid_d[k]                       = 1'b1;
          grant_entry_d[k*ENTRY_W +: ENTRY_W]    = pass_idx[pass_sel];
          grant_vector_d                         = grant_vector_d |
                                                   (NUM_ENTRIES'(1) << pass_idx[pass_sel]);
          grant_count_d                          = grant_count_d + CNT_W'(1);
        end
        pass_sel = pass_sel + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_valid_q  <= '0;
      grant_entry_q  <= '0;
      grant_vector_q <= '0;
      grant_count_q  <= '0;
    end else begin
      grant_valid_q  <= grant_valid_d;
      grant_entry_q  <= grant_entry_d;
      grant_vector_q <= grant_vector_d;
      grant_count_q  <= grant_count_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_entry  = grant_entry_q;
  assign grant_vector = grant_vector_q;
  assign grant_count  = grant_count_q;

endmodule

// File: tb/tb_issue_arbiter.sv
// Directed bench for issue_arbiter: driver pushes hand-computed grants, monitor pops and compares.
module tb_issue_arbiter;

  localparam int W = 3 + 12 + 16 + 2;

  logic        clk;
  logic        reset;
  logic [15:0] entry_valid;
  logic [15:0] entry_ready;
  logic [15:0] entry_is_ls;
  logic [95:0] entry_rob_idx;
  logic [5:0]  rob_head;
  logic [2:0]  fu_available;
  logic [2:0]  grant_valid;
  logic [11:0] grant_entry;
  logic [15:0] grant_vector;
  logic [1:0]  grant_count;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp;
  int           n_err;

  issue_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .entry_valid   (entry_valid),
    .entry_ready   (entry_ready),
    .entry_is_ls   (entry_is_ls),
    .entry_rob_idx (entry_rob_idx),
    .rob_head      (rob_head),
    .fu_available  (fu_available),
    .grant_valid   (grant_valid),
    .grant_entry   (grant_entry),
    .grant_vector  (grant_vector),
    .grant_count   (grant_count)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [95:0] rob_set(input logic [95:0] base, input int e, input logic [5:0] v);
    logic [95:0] r;
    r = base;
    r[e*6 +: 6] = v;
    return r;
  endfunction

  // Driver: one vector per cycle, expected registered response queued alongside.
  task automatic apply(input string nm, input logic rst,
                       input logic [15:0] v, input logic [15:0] r, input logic [15:0] ls,
                       input logic [95:0] rob, input logic [5:0] head, input logic [2:0] fu,
                       input logic [2:0] gv, input logic [11:0] ge,
                       input logic [15:0] gvec, input logic [1:0] gc);
    @(negedge clk);
    reset         = rst;
    entry_valid   = v;
    entry_ready   = r;
    entry_is_ls   = ls;
    entry_rob_idx = rob;
    rob_head      = head;
    fu_available  = fu;
    exp_q.push_back({gv, ge, gvec, gc});
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm);
    apply(nm, 1'b0, 16'h0, 16'h0, 16'h0, 96'h0, 6'd0, 3'b111, 3'b000, 12'h000, 16'h0000, 2'd0);
  endtask

  // Scoreboard monitor: samples just after each rising edge.
  initial begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    string        nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {grant_valid, grant_entry, grant_vector, grant_count};
        n_cmp++;
        if (act !== exp) begin
          n_err++;
          $display("FAIL %s: got gv=%b ge=%h vec=%h cnt=%0d, expected gv=%b ge=%h vec=%h cnt=%0d",
                   nm, act[32:30], act[29:18], act[17:2], act[1:0],
                   exp[32:30], exp[29:18], exp[17:2], exp[1:0]);
        end
      end
    end
  end

  initial begin
    logic [95:0] rob2;
    logic [95:0] rob3;
    logic [95:0] rob4;
    logic [95:0] robm;
    logic [95:0] rob5;
    logic [95:0] robd;
    logic [95:0] robh;

    n_cmp = 0;
    n_err = 0;
    reset         = 1'b1;
    entry_valid   = '1;
    entry_ready   = '1;
    entry_is_ls   = '1;
    entry_rob_idx = '1;
    rob_head      = '1;
    fu_available  = '1;

    // Reset held two cycles with all inputs high, then release.
    apply("rst_hold0", 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, '1, 6'h3F, 3'b111, 3'b000, 12'h000, 16'h0000, 2'd0);
    apply("rst_hold1", 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, '1, 6'h3F, 3'b111, 3'b000, 12'h000, 16'h0000, 2'd0);
    apply("rst_first", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, '1, 6'h3F, 3'b111, 3'b001, 12'h000, 16'h0001, 2'd1);
    apply("rst_second", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, '1, 6'h3F, 3'b111, 3'b010, 12'h010, 16'h0002, 2'd1);
    idle("idle_a");

    // Three entries ordered by age; first with no FU available at all.
    rob2 = rob_set(rob_set(rob_set(96'h0, 2, 6'd10), 5, 6'd4), 9, 6'd7);
    apply("no_fu", 1'b0, 16'h0224, 16'h0224, 16'h0, rob2, 6'd0, 3'b000, 3'b000, 12'h000, 16'h0000, 2'd0);
    apply("three_age", 1'b0, 16'h0224, 16'h0224, 16'h0, rob2, 6'd0, 3'b111, 3'b111, 12'h295, 16'h0224, 2'd3);
    idle("idle_b");

    // ROB head wrap: idx 63 older than idx 1 with head 62.
    rob3 = rob_set(rob_set(96'h0, 0, 6'd1), 1, 6'd63);
    apply("wrap_a", 1'b0, 16'h0003, 16'h0003, 16'h0, rob3, 6'd62, 3'b010, 3'b010, 12'h010, 16'h0002, 2'd1);
    apply("wrap_b", 1'b0, 16'h0001, 16'h0001, 16'h0, rob3, 6'd62, 3'b111, 3'b001, 12'h000, 16'h0001, 2'd1);
    idle("idle_c");

    // Load/store cap: one ls per cycle, oldest first, FUs alternate via fu_mask.
    rob4 = rob_set(rob_set(rob_set(rob_set(96'h0, 0, 6'd20), 1, 6'd18), 2, 6'd22), 3, 6'd19);
    apply("ls_c1", 1'b0, 16'h000F, 16'h000F, 16'h000F, rob4, 6'd16, 3'b111, 3'b001, 12'h001, 16'h0002, 2'd1);
    apply("ls_c2", 1'b0, 16'h000D, 16'h000D, 16'h000F, rob4, 6'd16, 3'b111, 3'b010, 12'h030, 16'h0008, 2'd1);
    apply("ls_c3", 1'b0, 16'h0005, 16'h0005, 16'h000F, rob4, 6'd16, 3'b111, 3'b001, 12'h000, 16'h0001, 2'd1);
    apply("ls_c4", 1'b0, 16'h0004, 16'h0004, 16'h000F, rob4, 6'd16, 3'b111, 3'b010, 12'h020, 16'h0004, 2'd1);
    idle("idle_d");

    // Cap skips the second ls but lets the younger ALU op through.
    robm = rob_set(rob_set(rob_set(96'h0, 0, 6'd0), 1, 6'd1), 2, 6'd2);
    apply("ls_mix", 1'b0, 16'h0007, 16'h0007, 16'h0003, robm, 6'd0, 3'b111, 3'b011, 12'h020, 16'h0005, 2'd2);
    idle("idle_e");

    // Entry mask and FU mask hold for exactly one cycle.
    rob5 = rob_set(rob_set(96'h0, 3, 6'd5), 4, 6'd6);
    apply("mask_c1", 1'b0, 16'h0008, 16'h0008, 16'h0, rob5, 6'd0, 3'b111, 3'b001, 12'h003, 16'h0008, 2'd1);
    apply("mask_c2", 1'b0, 16'h0018, 16'h0018, 16'h0, rob5, 6'd0, 3'b111, 3'b010, 12'h040, 16'h0010, 2'd1);
    apply("mask_c3", 1'b0, 16'h0018, 16'h0018, 16'h0, rob5, 6'd0, 3'b111, 3'b001, 12'h003, 16'h0008, 2'd1);
    idle("idle_f");

    // Duplicate ROB index: lower entry wins; only FU2 free.
    robd = rob_set(rob_set(96'h0, 6, 6'd9), 7, 6'd9);
    apply("dup_age", 1'b0, 16'h00C0, 16'h00C0, 16'h0, robd, 6'd0, 3'b100, 3'b100, 12'h600, 16'h0040, 2'd1);
    idle("idle_g");

    // idx equal to head is age 0; idx just below head is the youngest.
    robh = rob_set(rob_set(rob_set(96'h0, 0, 6'd39), 1, 6'd40), 2, 6'd41);
    apply("head_oldest", 1'b0, 16'h0007, 16'h0007, 16'h0, robh, 6'd40, 3'b001, 3'b001, 12'h001, 16'h0002, 2'd1);
    idle("idle_h");

    // Reset pulse drops in-flight selections and clears masks.
    apply("pre_rst", 1'b0, 16'h0224, 16'h0224, 16'h0, rob2, 6'd0, 3'b111, 3'b111, 12'h295, 16'h0224, 2'd3);
    apply("mid_rst", 1'b1, 16'h0224, 16'h0224, 16'h0, rob2, 6'd0, 3'b111, 3'b000, 12'h000, 16'h0000, 2'd0);
    apply("post_rst", 1'b0, 16'h0224, 16'h0224, 16'h0, rob2, 6'd0, 3'b111, 3'b111, 12'h295, 16'h0224, 2'd3);
    idle("idle_end");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0 pending", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
